// File: rtl/tiny_fir_pkg.sv
// Package shared by the tiny FIR and its coefficient loader.
// Contents:
//   TAP_WIDTH       default coefficient width used by both blocks
//   tap_ld_state_t  state encoding of the coefficient loader FSM
package tiny_fir_pkg;

   localparam int TAP_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STREAM    = 2'd1,
      WAIT_DONE = 2'd2,
      DONE      = 2'd3
   } tap_ld_state_t;

endpackage

// File: rtl/fir_tap_regfile.sv
// Coefficient storage for the FIR tap loader.
// G_NUM_TAPS x G_TAP_WIDTH flop array, one synchronous write port and one
// combinational read port. The array has no reset, so stored coefficients
// survive a reset of the loader.
// Ports:
//   clk      in   clock
//   we       in   write strobe (already qualified by the caller)
//   wr_addr  in   write address; addresses >= G_NUM_TAPS are ignored
//   wr_data  in   write data
//   rd_addr  in   read address; addresses >= G_NUM_TAPS read as zero
//   rd_data  out  combinational read data
module fir_tap_regfile #(
   parameter int G_NUM_TAPS   = 16,
   parameter int G_TAP_WIDTH  = 16,
   parameter int G_ADDR_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [G_ADDR_WIDTH-1:0] wr_addr,
   input  logic [G_TAP_WIDTH-1:0]  wr_data,
   input  logic [G_ADDR_WIDTH-1:0] rd_addr,
   output logic [G_TAP_WIDTH-1:0]  rd_data
);

   logic [G_TAP_WIDTH-1:0] mem_q [G_NUM_TAPS];
   logic                   wr_in_range;
   logic                   rd_in_range;

   // Range checks only exist when the address space is larger than the array.
   if (G_NUM_TAPS < (1 << G_ADDR_WIDTH)) begin : g_sparse
      assign wr_in_range = (wr_addr < G_ADDR_WIDTH'(G_NUM_TAPS));
      assign rd_in_range = (rd_addr < G_ADDR_WIDTH'(G_NUM_TAPS));
   end else begin : g_dense
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (we && wr_in_range) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = rd_in_range ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/fir_tap_loader.sv
// Transmit side of the FIR coefficient-load interface.
// A host writes G_NUM_TAPS coefficients while the block is idle. On an
// accepted load_start the coefficients are streamed in index order over a
// valid/ready link, then the block waits for the FIR's tap_done_in and
// reports either load_done (one-cycle pulse) or load_err (sticky timeout).
//
// Link handshake: a beat transfers on a rising edge where tap_dout_valid and
// tap_dout_ready are both 1. Once valid is raised it stays high, and tap_dout
// stays stable, until the beat transfers; ready may toggle freely and valid
// never waits on ready.
//
// Ports:
//   clk, reset (async, active low)
//   enable               gates load_start acceptance and the done timeout
//   wr_addr/wr_data/wr_en host coefficient write, honoured only when wr_ready
//   wr_ready             high only while idle
//   load_start           request to stream all taps
//   busy                 high in every state except IDLE
//   load_done            one-cycle pulse on successful completion
//   load_err             sticky timeout flag, cleared by an accepted load_start
//   tap_dout/tap_dout_valid/tap_dout_ready  stream to the FIR
//   tap_done_in          FIR reports it has absorbed all taps
//   dbg_state            current FSM state
module fir_tap_loader
   import tiny_fir_pkg::*;
#(
   parameter int G_NUM_TAPS     = 16,
   parameter int G_TAP_WIDTH    = TAP_WIDTH,
   parameter int G_ADDR_WIDTH   = $clog2(G_NUM_TAPS),
   parameter int G_DONE_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [G_ADDR_WIDTH-1:0] wr_addr,
   input  logic [G_TAP_WIDTH-1:0]  wr_data,
   input  logic                    wr_en,
   output logic                    wr_ready,
   input  logic                    load_start,
   output logic                    busy,
   output logic                    load_done,
   output logic                    load_err,
   output logic [G_TAP_WIDTH-1:0]  tap_dout,
   output logic                    tap_dout_valid,
   input  logic                    tap_dout_ready,
   input  logic                    tap_done_in,
   output logic [1:0]              dbg_state
);

   localparam int CNT_WIDTH = $clog2(G_DONE_TIMEOUT + 1);
   localparam logic [G_ADDR_WIDTH-1:0] LAST_IDX = G_ADDR_WIDTH'(G_NUM_TAPS - 1);
   localparam logic [CNT_WIDTH-1:0]    LAST_CNT = CNT_WIDTH'(G_DONE_TIMEOUT - 1);

   tap_ld_state_t           state_q, state_d;
   logic [G_ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [G_TAP_WIDTH-1:0]  dout_q, dout_d;
   logic                    valid_q, valid_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [G_ADDR_WIDTH-1:0] rd_addr;
   logic [G_TAP_WIDTH-1:0]  rd_data;

   // The read port looks one tap ahead so the next coefficient can be
   // registered on the same edge that accepts the current one. From IDLE
   // it points at tap 0 for the first beat.
   assign rd_addr = (state_q == STREAM) ? idx_q + G_ADDR_WIDTH'(1) : '0;

   fir_tap_regfile #(
      .G_NUM_TAPS   (G_NUM_TAPS),
      .G_TAP_WIDTH  (G_TAP_WIDTH),
      .G_ADDR_WIDTH (G_ADDR_WIDTH)
   ) u_regfile (
      .clk     (clk),
      .we      (wr_en && wr_ready),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (load_start && enable) begin
               state_d = STREAM;
               idx_d   = '0;
               dout_d  = rd_data;
               valid_d = 1'b1;
               err_d   = 1'b0;
            end
         end
         STREAM: begin
            // valid is always high here, so ready alone accepts the beat
            if (tap_dout_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = WAIT_DONE;
                  valid_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  idx_d  = idx_q + G_ADDR_WIDTH'(1);
                  dout_d = rd_data;
               end
            end
         end
         WAIT_DONE: begin
            // done is tested first so it wins over a same-cycle timeout
            if (tap_done_in) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (enable) begin
               if (cnt_q == LAST_CNT) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign wr_ready       = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign load_done      = done_q;
   assign load_err       = err_q;
   assign tap_dout       = dout_q;
   assign tap_dout_valid = valid_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader with 4 taps and a done timeout of 8 cycles.
// A coefficient array mirrors host writes; each accepted load pushes the
// whole array into exp_q, and a negedge monitor pops one entry per
// transferred beat. Timing, flag and latency expectations come from the
// block's rules written as plain counts.
module tb_fir_tap_loader;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int AW = 2;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic          wr_en = 1'b0;
   logic          load_start = 1'b0;
   logic          tap_dout_ready = 1'b0;
   logic          tap_done_in = 1'b0;
   logic          wr_ready, busy, load_done, load_err, tap_dout_valid;
   logic [W-1:0]  tap_dout;
   logic [1:0]    dbg_state;

   fir_tap_loader #(
      .G_NUM_TAPS     (N),
      .G_TAP_WIDTH    (W),
      .G_ADDR_WIDTH   (AW),
      .G_DONE_TIMEOUT (TO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_ready       (wr_ready),
      .load_start     (load_start),
      .busy           (busy),
      .load_done      (load_done),
      .load_err       (load_err),
      .tap_dout       (tap_dout),
      .tap_dout_valid (tap_dout_valid),
      .tap_dout_ready (tap_dout_ready),
      .tap_done_in    (tap_done_in),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int           n_cmp = 0;
   int           n_err = 0;
   logic [W-1:0] model_mem [N];
   logic [W-1:0] exp_q [$];
   int           beats = 0;
   int           done_pulses = 0;
   int           done_cyc = 0;
   int           start_cyc = 0;
   int           ready_mode = 0;   // 0 always, 1 pattern 1,0,0, 2 random, 3 never

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // ---------------- ready driver ----------------
   initial begin
      int pi = 0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       tap_dout_ready = 1'b1;
            1:       begin tap_dout_ready = (pi % 3 == 0); pi++; end
            2:       tap_dout_ready = 1'($urandom_range(0, 1));
            default: tap_dout_ready = 1'b0;
         endcase
      end
   end

   // ---------------- compare process ----------------
   logic         prev_valid = 1'b0;
   logic         prev_ready = 1'b0;
   logic [W-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (reset) begin
         check("wr_ready_is_not_busy", wr_ready, !busy);
         if (prev_valid && !prev_ready) begin
            check("stall_valid_held", tap_dout_valid, 1);
            check("stall_data_held", tap_dout, prev_data);
         end
         if (tap_dout_valid && tap_dout_ready) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("beat_data", tap_dout, exp_q.pop_front());
            beats++;
         end
         if (load_done) begin
            done_pulses++;
            done_cyc = cyc;
         end
         prev_valid = tap_dout_valid;
         prev_ready = tap_dout_ready;
         prev_data  = tap_dout;
      end else begin
         prev_valid = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_tap(input int a, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      step();
      wr_en = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic start_load(input bit accept);
      if (accept) begin
         for (int i = 0; i < N; i++) exp_q.push_back(model_mem[i]);
      end
      beats       = 0;
      done_pulses = 0;
      start_cyc   = cyc;
      load_start  = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   task automatic wait_stream_end(input bit noise, output int ncyc);
      ncyc = 0;
      while ((tap_dout_valid || exp_q.size() != 0) && ncyc < 200) begin
         if (noise) tap_done_in = 1'($urandom_range(0, 1));
         step();
         ncyc++;
      end
      tap_done_in = 1'b0;
      check("stream_within_budget", ncyc < 200, 1);
   endtask

   task automatic complete_load();
      tap_done_in = 1'b1;
      step();
      tap_done_in = 1'b0;
      step();
      step();
      check("load_done_once", done_pulses, 1);
      check("beats_per_load", beats, N);
      check("idle_after_done", busy, 0);
      check("no_err_after_done", load_err, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int d;
      bit saw_err;

      // Reset values while reset is held
      #12;
      check("rst_valid", tap_dout_valid, 0);
      check("rst_dout", tap_dout, 0);
      check("rst_busy", busy, 0);
      check("rst_done", load_done, 0);
      check("rst_err", load_err, 0);
      #11;
      reset = 1'b1;
      enable = 1'b1;
      step();
      check("rst_wr_ready", wr_ready, 1);

      // 1: basic load, ready=1, done right after last beat
      ready_mode = 0;
      write_tap(0, 16'h0011);
      write_tap(1, 16'h0022);
      write_tap(2, 16'h0033);
      write_tap(3, 16'h0044);
      step();
      start_load(1);
      check("t1_first_valid", tap_dout_valid, 1);
      check("t1_first_dout", tap_dout, 16'h0011);
      check("t1_busy", busy, 1);
      wait_stream_end(0, n);
      check("t1_stream_cycles", n, N);
      complete_load();
      check("t1_done_latency", done_cyc - start_cyc, N + 2);

      // 2: ready pattern 1,0,0 with fresh random taps
      for (int i = 0; i < N; i++) write_tap(i, W'($urandom));
      ready_mode = 1;
      step();
      start_load(1);
      wait_stream_end(0, n);
      check("t2_stream_stretched", n > N, 1);
      complete_load();

      // 3: no done -> timeout after TO waiting cycles
      ready_mode = 0;
      step();
      start_load(1);
      wait_stream_end(0, n);
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      check("t3_timeout_cycles", n, TO);
      check("t3_err_set", load_err, 1);
      check("t3_no_done", done_pulses, 0);
      start_load(1);
      check("t3_err_cleared", load_err, 0);
      wait_stream_end(0, n);
      complete_load();

      // 4: load_start and writes during STREAM are ignored
      ready_mode = 3;
      step();
      start_load(1);
      for (int k = 0; k < 2; k++) begin
         load_start = 1'b1;
         wr_en      = 1'b1;
         wr_addr    = AW'(k + 1);
         wr_data    = ~model_mem[k + 1];
         step();
      end
      load_start = 1'b0;
      wr_en      = 1'b0;
      ready_mode = 2;
      wait_stream_end(0, n);
      complete_load();
      ready_mode = 0;
      step();
      start_load(1);
      wait_stream_end(0, n);
      complete_load();

      // 5: async reset between beats 2 and 3, storage retained
      write_tap(0, 16'hA5A5);
      write_tap(1, 16'h5A5A);
      write_tap(2, 16'h0F0F);
      write_tap(3, 16'hF0F0);
      step();
      start_load(1);
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      check("t5_valid_low", tap_dout_valid, 0);
      check("t5_busy_low", busy, 0);
      check("t5_done_low", load_done, 0);
      check("t5_err_low", load_err, 0);
      check("t5_beats_before_reset", beats, 2);
      exp_q.delete();
      step();
      #3;
      reset = 1'b1;
      step();
      start_load(1);
      check("t5_first_dout_retained", tap_dout, 16'hA5A5);
      wait_stream_end(0, n);
      complete_load();

      // 6: enable gating of load_start and of the timeout
      enable = 1'b0;
      start_load(0);
      step();
      check("t6_ignored_busy", busy, 0);
      check("t6_ignored_beats", beats, 0);
      enable = 1'b1;
      start_load(1);
      wait_stream_end(0, n);
      enable = 1'b0;
      for (int k = 0; k < 10; k++) step();
      check("t6_still_waiting", busy, 1);
      check("t6_no_timeout", load_err, 0);
      complete_load();
      enable = 1'b1;

      // Random loads: random taps, random ready, random done delay,
      // done noise during STREAM
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) write_tap(i, W'($urandom));
         end
         ready_mode = 2;
         step();
         start_load(1);
         wait_stream_end(1, n);
         d = $urandom_range(0, TO + 2);
         if (d < TO) begin
            for (int k = 0; k < d; k++) step();
            complete_load();
         end else begin
            n = 0;
            while (busy && n < 3 * TO) begin
               step();
               n++;
            end
            saw_err = load_err;
            check("rand_timeout_cycles", n, TO);
            check("rand_timeout_err", saw_err, 1);
            check("rand_timeout_no_done", done_pulses, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
